seq_divide: RTL and testbench
=============================

# seq_divide

Sequential signed 32-bit divider for the miniSRC datapath: the inverse of the combinational multiplier. It produces quotient and remainder in the same 64-bit {HI, LO} layout, so the `div` instruction writes HI and LO the same way `mul` does. It uses a restoring, one-bit-per-cycle algorithm on operand magnitudes, followed by a sign-fix cycle. The control unit drives it with a start/busy/done handshake and stalls until done.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH bits
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-low reset
- start  in  1  request a divide; sampled only in IDLE
- A  in  WIDTH  dividend, two's complement; sampled with start
- B  in  WIDTH  divisor, two's complement; sampled with start
- busy  out  1  high while a divide is in progress (RUN or FIX)
- done  out  1  one-cycle pulse; result valid from this cycle on
- div_by_zero  out  1  registered with done; high if B was 0
- result  out  2*WIDTH  {remainder (HI), quotient (LO)}; held until the next done

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Latch sign_q = A[msb]^B[msb] and sign_r = A[msb].
  - Load unsigned magnitudes |A| into the dividend/quotient shift register and |B| into the divisor register.
  - Clear the partial remainder and the counter.
  - If B==0, go to FIX with the dbz flag set; otherwise go to RUN.
- RUN, per cycle:
  - Shift {rem, q} left by 1.
  - trial = rem - divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem = trial and q[0] = 1. Otherwise rem is unchanged and q[0] = 0.
  - The counter increments. After WIDTH iterations, go to FIX.
- FIX:
  - quotient = sign_q ? -q : q.
  - remainder = sign_r ? -rem : rem.
  - Register result, pulse done, register div_by_zero, then go to IDLE.
- Semantics: the quotient truncates toward zero. The remainder takes the sign of the dividend. A = quotient*B + remainder holds exactly in WIDTH bits.
- Divide by zero: quotient = all ones, remainder = A (unmodified), div_by_zero = 1.
- Overflow, -2^(WIDTH-1) / -1: quotient = 0x80000000, remainder = 0, no flag. The wrap is natural from unsigned magnitudes.
- start while busy: ignored. No queuing, and operands are not re-sampled.
- start in the same cycle that done pulses: ignored, because the FSM is in FIX. A new request is accepted from the following cycle.

## Timing
- Reset (clear low, async):
  - state = IDLE.
  - busy = 0, done = 0, div_by_zero = 0, result = 0.
  - All internal registers = 0.
  - Reset mid-operation aborts the operation and produces no done.
- Normal latency, with the start-sampling edge as edge 0:
  - RUN iterations occur at edges 1..WIDTH.
  - FIX occurs at edge WIDTH+1 (33): result is written and done=1 during the cycle after edge 33.
- Divide-by-zero latency: FIX at edge 1, so done is high after edge 1.
- busy is high from after edge 0 until the edge on which done rises; busy=0 in the done cycle.
- done is high for exactly one cycle.
- result and div_by_zero change only at a done edge or on reset.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE, RUN, FIX}
  - DIV_WIDTH = 32
  - counter width = $clog2(DIV_WIDTH+1)
- One natural sub-module, `div_step`: a combinational single restoring iteration. Inputs: rem, q, divisor. Outputs: rem_next, q_next.
- The FSM, counter, sign latches and sign-fix negation stay in `seq_divide`.
- Target size is about 150–250 lines.

## Test plan
- 100 / 7 -> done at edge 33, result = 0x00000002_0000000E, div_by_zero = 0, busy high for 33 cycles.
- -100 / 7 -> result = 0xFFFFFFFE_FFFFFFF2. 100 / -7 -> result = 0x00000002_FFFFFFF2.
- 5 / 0 -> done after edge 1, div_by_zero = 1, result = 0x00000005_FFFFFFFF. A following 6 / 3 returns 0x00000000_00000002 with div_by_zero = 0.
- 0x80000000 / 0xFFFFFFFF -> result = 0x00000000_80000000, no flag. 7 / 100 -> result = 0x00000007_00000000.
- Assert start at edge 5 of a 100/7 run with A = 1, B = 1 -> ignored, and the result is still 0x00000002_0000000E.
- Pulse clear low between edges 10 and 11 of a run:
  - Outputs go to 0 immediately (async) and no done appears.
  - A new 9 / 3 started afterwards completes in 33 cycles with result 0x00000000_00000003.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential signed divider.
// Holds the FSM encoding and the iteration counter width.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      FIX  = ST_FIX
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes.
// Shifts {rem, q} left, trial-subtracts the divisor, restores on borrow.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   assign shifted = {rem, q[WIDTH-1]};
   assign trial   = shifted - {1'b0, divisor};

   always_comb begin
      rem_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
         rem_next = trial[WIDTH-1:0];
         q_next   = {q[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/seq_divide.sv
// Sequential signed divider: result = {remainder, quotient}.
// Restoring magnitude loop, then one sign-fix cycle.
module seq_divide
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic [2*WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] divisor;
   logic             sign_q;
   logic             sign_r;
   logic             dbz;

   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] q_fix;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem     (rem),
      .q       (q),
      .divisor (divisor),
      .rem_next(rem_next),
      .q_next  (q_next)
   );

   assign rem_fix = sign_r ? -rem : rem;
   assign q_fix   = sign_q ? -q : q;
   assign busy    = (state != IDLE);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         q           <= '0;
         divisor     <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dbz         <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         result      <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  sign_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                  sign_r  <= A[WIDTH-1];
                  divisor <= mag(B);
                  cnt     <= '0;
                  if (B == '0) begin
                     // FIX re-applies A's sign to |A|, returning A itself
                     dbz    <= 1'b1;
                     sign_q <= 1'b0;
                     q      <= '1;
                     rem    <= mag(A);
                     state  <= FIX;
                  end else begin
                     dbz   <= 1'b0;
                     q     <= mag(A);
                     rem   <= '0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               rem <= rem_next;
               q   <= q_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               result      <= {rem_fix, q_fix};
               done        <= 1'b1;
               div_by_zero <= dbz;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divide.sv
// Directed self-checking bench for seq_divide.
// Each task drives one scenario and checks against hand-computed values.
module tb_seq_divide;

   logic        clock;
   logic        clear;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [63:0] result;

   int checks;
   int errors;

   seq_divide dut (
      .clock      (clock),
      .clear      (clear),
      .start      (start),
      .A          (A),
      .B          (B),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .result     (result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // start sampled at edge 0; lat = edge index where done is seen
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          input int inj, output int lat,
                          output int busy_n);
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      lat = 0;
      busy_n = 0;
      while (lat < 40) begin
         if (busy) busy_n++;
         @(posedge clock);
         #1;
         lat++;
         if (lat == inj) begin
            start = 1'b1;
            A = 32'd1;
            B = 32'd1;
         end else begin
            start = 1'b0;
         end
         if (done) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      clear = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000 || result !== 64'd0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b dbz=%b result=%h want 0",
                  busy, done, div_by_zero, result);
      end
      clear = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_basic;
      int lat;
      int bn;
      run_div(32'd100, 32'd7, 0, lat, bn);
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("FAIL basic_latency: got %0d want 33", lat);
      end
      checks++;
      if (bn !== 33) begin
         errors++;
         $display("FAIL basic_busy: got %0d want 33", bn);
      end
      checks++;
      if (result !== 64'h00000002_0000000E || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: got %h/%b want 000000020000000e/0",
                  result, div_by_zero);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_in_done: got %b want 0", busy);
      end
      @(posedge clock);
      #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_width: got %b want 0", done);
      end
   endtask

   task automatic test_signs;
      int lat;
      int bn;
      run_div(-32'sd100, 32'd7, 0, lat, bn);
      checks++;
      if (result !== 64'hFFFFFFFE_FFFFFFF2) begin
         errors++;
         $display("FAIL neg_dividend: got %h want fffffffefffffff2", result);
      end
      run_div(32'd100, -32'sd7, 0, lat, bn);
      checks++;
      if (result !== 64'h00000002_FFFFFFF2) begin
         errors++;
         $display("FAIL neg_divisor: got %h want 00000002fffffff2", result);
      end
   endtask

   task automatic test_div_zero;
      int lat;
      int bn;
      run_div(32'd5, 32'd0, 0, lat, bn);
      checks++;
      if (lat !== 1 || bn !== 1) begin
         errors++;
         $display("FAIL dbz_latency: lat=%0d busy=%0d want 1/1", lat, bn);
      end
      checks++;
      if (result !== 64'h00000005_FFFFFFFF || div_by_zero !== 1'b1) begin
         errors++;
         $display("FAIL dbz_result: got %h/%b want 00000005ffffffff/1",
                  result, div_by_zero);
      end
      @(posedge clock);
      #1;
      checks++;
      if (div_by_zero !== 1'b1) begin
         errors++;
         $display("FAIL dbz_hold: got %b want 1", div_by_zero);
      end
      run_div(32'd6, 32'd3, 0, lat, bn);
      checks++;
      if (result !== 64'h00000000_00000002 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL after_dbz: got %h/%b want 0000000000000002/0",
                  result, div_by_zero);
      end
      run_div(32'hFFFFFFF9, 32'd0, 0, lat, bn);
      checks++;
      if (result !== 64'hFFFFFFF9_FFFFFFFF || div_by_zero !== 1'b1) begin
         errors++;
         $display("FAIL dbz_neg: got %h/%b want fffffff9ffffffff/1",
                  result, div_by_zero);
      end
   endtask

   task automatic test_edges;
      int lat;
      int bn;
      run_div(32'h80000000, 32'hFFFFFFFF, 0, lat, bn);
      checks++;
      if (result !== 64'h00000000_80000000 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL overflow: got %h/%b want 0000000080000000/0",
                  result, div_by_zero);
      end
      run_div(32'd7, 32'd100, 0, lat, bn);
      checks++;
      if (result !== 64'h00000007_00000000) begin
         errors++;
         $display("FAIL small_dividend: got %h want 0000000700000000", result);
      end
      run_div(32'h80000000, 32'h80000000, 0, lat, bn);
      checks++;
      if (result !== 64'h00000000_00000001) begin
         errors++;
         $display("FAIL min_by_min: got %h want 0000000000000001", result);
      end
   endtask

   task automatic test_start_busy;
      int lat;
      int bn;
      run_div(32'd100, 32'd7, 5, lat, bn);
      checks++;
      if (lat !== 33 || result !== 64'h00000002_0000000E) begin
         errors++;
         $display("FAIL start_busy: lat=%0d result=%h want 33/000000020000000e",
                  lat, result);
      end
      // start held into the FIX edge must not launch a new divide
      run_div(32'd100, 32'd7, 32, lat, bn);
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || result !== 64'h00000002_0000000E) begin
         errors++;
         $display("FAIL start_in_fix: busy=%b result=%h want 0/000000020000000e",
                  busy, result);
      end
   endtask

   task automatic test_clear_midrun;
      int lat;
      int bn;
      int seen;
      A = 32'd100;
      B = 32'd7;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      clear = 1'b0;
      #1;
      checks++;
      if ({busy, done, div_by_zero} !== 3'b000 || result !== 64'd0) begin
         errors++;
         $display("FAIL clear_async: busy=%b done=%b dbz=%b result=%h want 0",
                  busy, done, div_by_zero, result);
      end
      #1;
      clear = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (done || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL clear_abort: activity=%0d want 0", seen);
      end
      run_div(32'd9, 32'd3, 0, lat, bn);
      checks++;
      if (lat !== 33 || result !== 64'h00000000_00000003) begin
         errors++;
         $display("FAIL after_clear: lat=%0d result=%h want 33/0000000000000003",
                  lat, result);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_edges();
      test_start_busy();
      test_clear_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
